// File: rtl/alarm_trigger_if.sv
// Alarm-trigger bus: the time digits, arm switch, buttons and second tick in,
// and the buzzer/status outputs back to the panel.
interface alarm_trigger_if;
  logic       sec_tick;
  logic       alarm_en;
  logic [3:0] al_h1, al_h0, al_m1, al_m0;
  logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
  logic       stop_n;
  logic       snooze_n;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_left;

  modport master (
    output sec_tick, alarm_en, al_h1, al_h0, al_m1, al_m0,
           cur_h1, cur_h0, cur_m1, cur_m0, stop_n, snooze_n,
    input  buzzer, ringing, snoozing, snooze_left
  );

  modport slave (
    input  sec_tick, alarm_en, al_h1, al_h0, al_m1, al_m0,
           cur_h1, cur_h0, cur_m1, cur_m0, stop_n, snooze_n,
    output buzzer, ringing, snoozing, snooze_left
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm trigger: rings a beeping buzzer on the rising edge of an alarm/time
// match, with stop, limited snooze and ring timeout.
module alarm_trigger #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic           clk,
  input  logic           reset,
  alarm_trigger_if.slave bus
);
  localparam logic [9:0] RING_LIM   = 10'(RING_SECS);
  localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_SECS);
  localparam logic [2:0] SNOOZE_MAX = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

  state_t     state;
  logic [9:0] sec_cnt;
  logic [2:0] snooze_left;
  logic       beep, buzzer, ringing, snoozing;

  // [0],[1] synchronize; [2] holds the previous synced value for edge detect
  logic [2:0] stop_sync, snz_sync;
  logic       stop_p, snz_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_sync <= '1;
      snz_sync  <= '1;
      stop_p    <= 1'b0;
      snz_p     <= 1'b0;
    end else begin
      stop_sync <= {stop_sync[1:0], bus.stop_n};
      snz_sync  <= {snz_sync[1:0], bus.snooze_n};
      stop_p    <= stop_sync[2] & ~stop_sync[1];
      snz_p     <= snz_sync[2] & ~snz_sync[1];
    end
  end

  logic match, match_q, trig;
  assign match = ({bus.al_h1, bus.al_h0, bus.al_m1, bus.al_m0} ==
                  {bus.cur_h1, bus.cur_h0, bus.cur_m1, bus.cur_m0});

  // match_q resets high so a match already present out of reset never fires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) match_q <= 1'b1;
    else       match_q <= match;
  end

  assign trig = match & ~match_q & bus.alarm_en;

  logic to_idle, to_ring, to_snz, count;
  always_comb begin
    to_idle = 1'b0;
    to_ring = 1'b0;
    to_snz  = 1'b0;
    count   = 1'b0;
    if (!bus.alarm_en) begin
      to_idle = 1'b1;
    end else begin
      case (state)
        IDLE: to_ring = trig;
        RING: begin
          if (stop_p || (snz_p && snooze_left == 3'd0)) to_idle = 1'b1;
          else if (snz_p)                               to_snz  = 1'b1;
          else if (bus.sec_tick) begin
            if (sec_cnt + 10'd1 == RING_LIM) to_idle = 1'b1;
            else                             count   = 1'b1;
          end
        end
        SNOOZE: begin
          if (stop_p) to_idle = 1'b1;
          else if (bus.sec_tick) begin
            if (sec_cnt + 10'd1 == SNOOZE_LIM) to_ring = 1'b1;
            else                               count   = 1'b1;
          end
        end
        default: to_idle = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sec_cnt     <= '0;
      snooze_left <= SNOOZE_MAX;
      beep        <= 1'b0;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
    end else if (to_idle) begin
      state    <= IDLE;
      sec_cnt  <= '0;
      beep     <= 1'b0;
      buzzer   <= 1'b0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else if (to_ring) begin
      state    <= RING;
      sec_cnt  <= '0;
      beep     <= 1'b1;
      buzzer   <= 1'b1;
      ringing  <= 1'b1;
      snoozing <= 1'b0;
      // a fresh alarm event restores the snooze budget; re-ring after snooze does not
      if (state == IDLE) snooze_left <= SNOOZE_MAX;
    end else if (to_snz) begin
      state       <= SNOOZE;
      sec_cnt     <= '0;
      snooze_left <= snooze_left - 3'd1;
      beep        <= 1'b0;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b1;
    end else if (count) begin
      sec_cnt <= sec_cnt + 10'd1;
      if (state == RING) begin
        beep   <= ~beep;
        buzzer <= ~beep;
      end
    end
  end

  assign bus.buzzer      = buzzer;
  assign bus.ringing     = ringing;
  assign bus.snoozing    = snoozing;
  assign bus.snooze_left = snooze_left;
endmodule
